load_store_unit: RTL and testbench

- Sits directly upstream of the word-wide data memory (DATA_MEM) in the MIPS datapath.
- Accepts byte-addressed load/store requests for LB/LBU/LH/LHU/LW/SB/SH/SW.
- Converts each request into word-addressed memory read/write strobes. Sub-word stores use read-modify-write.
- Returns aligned, sign- or zero-extended load data to the writeback side, plus a done pulse and a misalignment flag.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, completion and data-memory signals of the load/store unit.
// The slave modport is the unit itself; master is its environment (core side plus memory).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  i_req;
  logic                  i_we;
  logic [1:0]            i_size;
  logic                  i_unsigned;
  logic [31:0]           i_addr;
  logic [31:0]           i_wdata;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_misaligned;
  logic [31:0]           o_rdata;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_read;
  logic                  o_mem_write;
  logic [31:0]           o_mem_wdata;
  logic [31:0]           i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_rdata,
    output o_busy, o_done, o_misaligned, o_rdata,
           o_mem_addr, o_mem_read, o_mem_write, o_mem_wdata
  );

  modport master (
    output i_req, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_rdata,
    input  o_busy, o_done, o_misaligned, o_rdata,
           o_mem_addr, o_mem_read, o_mem_write, o_mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory.
// Sub-word stores are read-modify-write; all outputs are registered.
module load_store_unit #(
  parameter int ADDR_WIDTH = 5
) (
  input logic              i_clk,
  input logic              i_rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t                state, state_n;
  logic                  we_q, we_n;
  logic [1:0]            size_q, size_n;
  logic                  uns_q, uns_n;
  logic [1:0]            lane_q, lane_n;
  logic [15:0]           wdata_q, wdata_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  mis_q, mis_n;
  logic                  rd_q, rd_n;
  logic                  wr_q, wr_n;
  logic [31:0]           rdata_q, rdata_n;
  logic [31:0]           mem_wdata_q, mem_wdata_n;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_n;

  // Address bits above the memory window wrap away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.i_addr[31:ADDR_WIDTH+2];

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = a[0];
      2'b10:   is_bad = |a;
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] size,
                                        input logic [1:0] lane, input logic [15:0] d);
    merge = w;
    if (size == 2'b00) merge[{lane, 3'b000} +: 8] = d[7:0];
    else               merge[{lane[1], 4'b0000} +: 16] = d;
  endfunction

  always_comb begin
    state_n     = state;
    we_n        = we_q;
    size_n      = size_q;
    uns_n       = uns_q;
    lane_n      = lane_q;
    wdata_n     = wdata_q;
    mis_n       = 1'b0;
    rdata_n     = rdata_q;
    mem_wdata_n = mem_wdata_q;
    mem_addr_n  = mem_addr_q;
    case (state)
      IDLE: if (bus.i_req) begin
        we_n    = bus.i_we;
        size_n  = bus.i_size;
        uns_n   = bus.i_unsigned;
        lane_n  = bus.i_addr[1:0];
        wdata_n = bus.i_wdata[15:0];
        rdata_n = '0;
        if (is_bad(bus.i_size, bus.i_addr[1:0])) begin
          state_n = DONE;
          mis_n   = 1'b1;
        end else begin
          mem_addr_n = bus.i_addr[ADDR_WIDTH+1:2];
          if (bus.i_we && bus.i_size == 2'b10) begin
            state_n     = WR;
            mem_wdata_n = bus.i_wdata;
          end else begin
            state_n = RD;
          end
        end
      end
      RD:  state_n = CAP;
      // Memory word is on i_mem_rdata this cycle: either extract the load
      // result or register the merged word as the write data.
      CAP: if (we_q) begin
        state_n     = WR;
        mem_wdata_n = merge(bus.i_mem_rdata, size_q, lane_q, wdata_q);
      end else begin
        state_n = DONE;
        rdata_n = extract(bus.i_mem_rdata, size_q, uns_q, lane_q);
      end
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    rd_n   = (state_n == RD);
    wr_n   = (state_n == WR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state       <= state_n;
      we_q        <= we_n;
      size_q      <= size_n;
      uns_q       <= uns_n;
      lane_q      <= lane_n;
      wdata_q     <= wdata_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      mis_q       <= mis_n;
      rd_q        <= rd_n;
      wr_q        <= wr_n;
      rdata_q     <= rdata_n;
      mem_wdata_q <= mem_wdata_n;
      mem_addr_q  <= mem_addr_n;
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_misaligned = mis_q;
  assign bus.o_rdata      = rdata_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_read   = rd_q;
  assign bus.o_mem_write  = wr_q;
  assign bus.o_mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_idx;
  logic [31:0]   pre_val;

  // Read data appears the cycle after the read strobe; writes commit at the edge.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.o_mem_write) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_read) bus.i_mem_rdata <= mem[bus.o_mem_addr];
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          pidx;
    logic [31:0] pval;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx[AW-1:0];
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic extra_req,
                       output int lat, output int nrd, output int nwr, output int ndone,
                       output logic [31:0] maddr, output logic [31:0] mwdata,
                       output logic [31:0] rdata, output logic mis);
    lat = 0; nrd = 0; nwr = 0; ndone = 0;
    maddr = '0; mwdata = '0; rdata = '0; mis = 1'b0;
    @(negedge clk);
    bus.i_req      = 1'b1;
    bus.i_we       = we;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    bus.i_addr     = addr;
    bus.i_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.o_mem_read) begin
        nrd++;
        maddr = 32'(bus.o_mem_addr);
      end
      if (bus.o_mem_write) begin
        nwr++;
        maddr  = 32'(bus.o_mem_addr);
        mwdata = bus.o_mem_wdata;
      end
      if (bus.o_done) begin
        ndone++;
        if (lat == 0) begin
          lat   = c;
          rdata = bus.o_rdata;
          mis   = bus.o_misaligned;
        end
      end
      bus.i_req = extra_req && (c <= 2);
      @(negedge clk);
    end
    bus.i_req = 1'b0;
  endtask

  initial begin
    int          lat, nrd, nwr, ndone;
    logic [31:0] maddr, mwdata, rdata;
    logic        mis;
    logic        found;

    vecs.push_back('{"sw_0c",       1, 2'b10, 0, 32'h0C, 32'h11223344, 3, 32'h8899AABB, 32'h0,        0, 2, 0, 1, 3, 32'h11223344, 32'h11223344});
    vecs.push_back('{"lb_0e",       0, 2'b00, 0, 32'h0E, 32'h0,        3, 32'h8899AABB, 32'hFFFFFF99, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lbu_0e",      0, 2'b00, 1, 32'h0E, 32'h0,        3, 32'h8899AABB, 32'h00000099, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lh_0e",       0, 2'b01, 0, 32'h0E, 32'h0,        3, 32'h8899AABB, 32'hFFFF8899, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lw_0c",       0, 2'b10, 0, 32'h0C, 32'h0,        3, 32'h8899AABB, 32'h8899AABB, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lw_0e_mis",   0, 2'b10, 0, 32'h0E, 32'h0,        3, 32'h8899AABB, 32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lhu_0c",      0, 2'b01, 1, 32'h0C, 32'h0,        3, 32'h8899AABB, 32'h0000AABB, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"sh_0d_mis",   1, 2'b01, 0, 32'h0D, 32'h0000FFFF, 3, 32'h8899AABB, 32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lb_0c",       0, 2'b00, 0, 32'h0C, 32'h0,        3, 32'h8899AABB, 32'hFFFFFFBB, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"size11_mis",  0, 2'b11, 0, 32'h0C, 32'h0,        3, 32'h8899AABB, 32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lb_0f",       0, 2'b00, 0, 32'h0F, 32'h0,        3, 32'h8899AABB, 32'hFFFFFF88, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"lbu_0d",      0, 2'b00, 1, 32'h0D, 32'h0,        3, 32'h8899AABB, 32'h000000AA, 0, 3, 1, 0, 3, 32'h0,        32'h8899AABB});
    vecs.push_back('{"sb_0d",       1, 2'b00, 0, 32'h0D, 32'h123456EE, 3, 32'h8899AABB, 32'h0,        0, 4, 1, 1, 3, 32'h8899EEBB, 32'h8899EEBB});
    vecs.push_back('{"sh_0e",       1, 2'b01, 0, 32'h0E, 32'h0000CAFE, 3, 32'h8899AABB, 32'h0,        0, 4, 1, 1, 3, 32'hCAFEAABB, 32'hCAFEAABB});
    vecs.push_back('{"sh_0c",       1, 2'b01, 0, 32'h0C, 32'h00001234, 3, 32'h8899AABB, 32'h0,        0, 4, 1, 1, 3, 32'h88991234, 32'h88991234});
    vecs.push_back('{"lw_84_wrap",  0, 2'b10, 0, 32'h84, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 1, 0, 1, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{"sw_8c_wrap",  1, 2'b10, 0, 32'h8C, 32'h0A0B0C0D, 3, 32'h8899AABB, 32'h0,        0, 2, 0, 1, 3, 32'h0A0B0C0D, 32'h0A0B0C0D});

    rst_n          = 1'b0;
    pre_en         = 1'b0;
    pre_idx        = '0;
    pre_val        = '0;
    bus.i_req      = 1'b0;
    bus.i_we       = 1'b0;
    bus.i_size     = 2'b00;
    bus.i_unsigned = 1'b0;
    bus.i_addr     = '0;
    bus.i_wdata    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy",      32'(bus.o_busy), 0);
    check("rst_done",      32'(bus.o_done), 0);
    check("rst_mis",       32'(bus.o_misaligned), 0);
    check("rst_mem_read",  32'(bus.o_mem_read), 0);
    check("rst_mem_write", 32'(bus.o_mem_write), 0);
    check("rst_rdata",     bus.o_rdata, 0);
    check("rst_mem_wdata", bus.o_mem_wdata, 0);
    check("rst_mem_addr",  32'(bus.o_mem_addr), 0);

    foreach (vecs[i]) begin
      preload(vecs[i].pidx, vecs[i].pval);
      issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 1'b0,
            lat, nrd, nwr, ndone, maddr, mwdata, rdata, mis);
      check({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
      check({vecs[i].name, "_ndone"}, ndone, 1);
      check({vecs[i].name, "_mis"},   32'(mis), 32'(vecs[i].exp_mis));
      check({vecs[i].name, "_nrd"},   nrd, vecs[i].exp_rd);
      check({vecs[i].name, "_nwr"},   nwr, vecs[i].exp_wr);
      if (!vecs[i].we || vecs[i].exp_mis) check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_rd + vecs[i].exp_wr > 0) check({vecs[i].name, "_maddr"}, maddr, vecs[i].exp_maddr);
      if (vecs[i].exp_wr > 0) check({vecs[i].name, "_mwdata"}, mwdata, vecs[i].exp_mwdata);
      check({vecs[i].name, "_mem"}, mem[vecs[i].pidx], vecs[i].exp_mem);
    end

    // Extra request pulses while busy must be dropped, not queued.
    preload(3, 32'h8899AABB);
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b1, lat, nrd, nwr, ndone, maddr, mwdata, rdata, mis);
    check("busy_req_ndone", ndone, 1);
    check("busy_req_nrd",   nrd, 1);
    check("busy_req_rdata", rdata, 32'h8899AABB);

    // Reset asserted in the middle of the WR cycle of an SH.
    preload(3, 32'h8899AABB);
    @(negedge clk);
    bus.i_req      = 1'b1;
    bus.i_we       = 1'b1;
    bus.i_size     = 2'b01;
    bus.i_unsigned = 1'b0;
    bus.i_addr     = 32'h0E;
    bus.i_wdata    = 32'h0000CAFE;
    @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (bus.o_mem_write) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_reach_wr", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_write", 32'(bus.o_mem_write), 0);
    check("rst_mid_busy",      32'(bus.o_busy), 0);
    check("rst_mid_done",      32'(bus.o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_done) ndone++;
    end
    check("rst_mid_no_done", ndone, 0);
    check("rst_mid_mem",     mem[3], 32'h8899AABB);
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, lat, nrd, nwr, ndone, maddr, mwdata, rdata, mis);
    check("post_rst_lw_lat",   lat, 3);
    check("post_rst_lw_rdata", rdata, 32'h8899AABB);
    check("post_rst_lw_ndone", ndone, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
